cpu_data_mem: RTL
=================

// Module: cpu_data_mem
// PURPOSE
//  Parametrised single-port data memory for the 8-bit CPU; successor of the fixed 256x8 RAM.
//  Adds registered (1-cycle) reads with rvalid, a req/ready handshake, and a hardware
//  zero-fill sweep after reset instead of simulation-only init. Sits between CPU datapath and bus.
// PARAMETERS
//  DATA_W   8   word width in bits
//  ADDR_W   8   address width; DEPTH = 2**ADDR_W words
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  req         in   1       access request, qualified by ready
//  we          in   1       1 = write, 0 = read (sampled with req)
//  addr        in   ADDR_W  word address
//  wdata       in   DATA_W  write data
//  ready       out  1       memory accepts req this cycle
//  rdata       out  DATA_W  read data, valid when rvalid
//  rvalid      out  1       one-cycle pulse, cycle after accepted read
//  init_done   out  1       zero-fill sweep complete
//  parity_err  out  1       parity mismatch on read, aligned with rvalid
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=INIT, clr_ptr=0, ready=0, init_done=0, rvalid=0,
//    rdata=0, parity_err=0. Storage array itself has no reset; it is cleared by sweep.
//  - INIT: one word per cycle, mem[clr_ptr]<=0, clr_ptr++; at clr_ptr==DEPTH-1 write then
//    go IDLE. Exactly DEPTH cycles after reset release: init_done=1, ready=1 (sticky).
//  - req during INIT: ignored, no side effect, no rvalid.
//  - IDLE: ready=1 every cycle; accept = req & ready. One access per cycle (single port).
//  - Write: mem[addr]<=wdata at accepting edge; no rvalid.
//  - Read: rdata<=mem[addr], rvalid=1 on the following cycle only; back-to-back reads
//    each cycle give consecutive rvalid pulses. rdata holds last value when rvalid=0.
//  - Write at cycle N then read same addr at N+1 returns the new data (no stale read).
//  - Address wraps naturally in ADDR_W bits; no out-of-range case exists.
//  - Reset mid-operation: pending rvalid dropped, sweep restarts from address 0.
// CONFIGURATION
//  CPU_DATA_MEM_PARITY_EN defined: storage DATA_W+1 wide, extra bit = even parity (^wdata)
//    written on every write (0 for sweep zeros). On read, parity_err <= stored parity !=
//    ^stored data, registered alongside rvalid; 0 whenever rvalid=0.
//  Not defined: storage DATA_W wide, parity_err tied 0.
// STRUCTURE
//  cpu_pkg: enum mem_state_t {MEM_INIT, MEM_IDLE}; default DATA_W/ADDR_W localparams.
//  Sub-module cpu_mem_array: plain synchronous-write, synchronous-read storage
//    (WIDTH, ADDR_W params, we/addr/wdata/rdata); cpu_data_mem holds FSM, sweep, handshake.
// TESTING (DATA_W=8, ADDR_W=8)
//  - Release rst_n at t0 -> ready=0 for 256 cycles, init_done=1 and ready=1 at cycle 256;
//    reads of 0x00, 0x7F, 0xFF return 0x00.
//  - req during INIT, we=1 addr 0x0A wdata 0x55 -> ignored; later read 0x0A returns 0x00.
//  - Write 0x0A=2, 0x0B=3, 0x80=1; reads 0x0A,0x0B,0x80 back-to-back -> rvalid 3 consecutive
//    cycles, rdata 2,3,1.
//  - Write 0x0C=4 then read 0x0C next cycle -> rdata=4 one cycle later.
//  - Assert rst_n=0 at sweep address 100 and mid-read -> rvalid drops at once, sweep restarts,
//    full 256-cycle INIT repeats.
//  - PARITY_EN: write 0x81=0x03, backdoor-flip stored parity bit, read -> parity_err=1 with
//    rvalid; unflipped read -> 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Package shared by the CPU data memory files.
// Holds the memory controller state encoding, default geometry and a parity helper.
// Optional feature macro used by the files that import this package:
//   CPU_DATA_MEM_PARITY_EN -- adds one even-parity bit per stored word.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic {
    MEM_INIT = 1'b0,
    MEM_IDLE = 1'b1
  } mem_state_t;

  // Even parity of up to 64 bits; narrower values are zero-extended,
  // which does not change the XOR reduction.
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/cpu_mem_array.sv
// Plain storage array: synchronous write, synchronous (registered) read.
// No reset on the storage or the read register; the controller clears the array.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   addr   in   word address (ADDR_W)
//   wdata  in   write word (WIDTH)
//   rdata  out  word read at the previous edge (WIDTH)
module cpu_mem_array #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and read never target the array in the same cycle from the
  // controller's point of view, so read-during-write ordering is irrelevant.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_data_mem.sv
// Single-port data memory for the 8-bit CPU with a req/ready handshake,
// 1-cycle registered reads flagged by rvalid, and a hardware zero-fill sweep
// that runs after every reset.
// Handshake: an access is accepted on a rising edge where req & ready are both 1.
//   ready is 0 during the sweep and 1 (sticky) afterwards; an accepted read
//   produces rvalid=1 for exactly the next cycle with rdata valid; writes give no rvalid.
// Optional feature: define CPU_DATA_MEM_PARITY_EN to store an even-parity bit per
//   word and flag a mismatch on parity_err together with rvalid.
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   req         in   access request
//   we          in   1 = write, 0 = read
//   addr        in   word address (ADDR_W)
//   wdata       in   write data (DATA_W)
//   ready       out  memory accepts req this cycle
//   rdata       out  read data, valid with rvalid, holds otherwise (DATA_W)
//   rvalid      out  read data valid pulse
//   init_done   out  zero-fill sweep finished
//   parity_err  out  stored parity mismatch on the read being returned
module cpu_data_mem
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              init_done,
  output logic              parity_err
);

`ifdef CPU_DATA_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  mem_state_t        state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              ready_q;
  logic              init_done_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;

  logic              accept;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [MEM_W-1:0]  arr_wdata;
  logic [MEM_W-1:0]  arr_rdata;

  assign accept = req & ready_q;

  // During the sweep the array is owned by the clear pointer; bus requests
  // are ignored because ready_q is still 0.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = addr;
    arr_wdata = '0;
    if (state_q == MEM_INIT) begin
      arr_we   = 1'b1;
      arr_addr = clr_ptr_q;
    end else begin
      arr_we = accept & we;
`ifdef CPU_DATA_MEM_PARITY_EN
      arr_wdata = {even_par(64'(wdata)), wdata};
`else
      arr_wdata = wdata;
`endif
    end
  end

  cpu_mem_array #(
    .WIDTH (MEM_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MEM_INIT;
      clr_ptr_q   <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      case (state_q)
        MEM_INIT: begin
          rvalid_q  <= 1'b0;
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == '1) begin
            state_q     <= MEM_IDLE;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        MEM_IDLE: begin
          rvalid_q <= accept & ~we;
        end
        default: begin
          state_q <= MEM_INIT;
        end
      endcase
    end
  end

  // The array read register updates every cycle, so the last returned word
  // is captured here to keep rdata stable between rvalid pulses.
  always_comb begin
    hold_d = hold_q;
    if (rvalid_q) begin
      hold_d = arr_rdata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign ready     = ready_q;
  assign init_done = init_done_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rvalid_q ? arr_rdata[DATA_W-1:0] : hold_q;

`ifdef CPU_DATA_MEM_PARITY_EN
  assign parity_err = rvalid_q &
                      (arr_rdata[DATA_W] != even_par(64'(arr_rdata[DATA_W-1:0])));
`else
  assign parity_err = 1'b0;
`endif

endmodule
